cmsdk_ahb_sram_bridge: RTL and testbench
========================================

Name: cmsdk_ahb_sram_bridge

Overview:
- AHB-Lite slave that acts as the initiator on the synchronous single-port SRAM interface (ADDR/WDATA/WREN/CS in, RDATA out with one-cycle read latency) used by the FPGA block-RAM and on-chip SRAM macros.
- Converts AHB address/data-phase transfers into SRAM accesses with zero wait states.
- A one-entry write buffer resolves write-data-phase vs. read-address-phase collisions.
- Read data is forwarded from the buffer when it holds pending bytes for the same word.

Parameters:
- AW, 16, AHB byte-address width; SRAM word-address width is AW-2.

Ports:
- HCLK  in  1  system clock; all state on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HSEL  in  1  slave select
- HREADY  in  1  bus ready (transfer accepted when high)
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HADDR  in  AW  byte address
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  constant 1
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  32  read data
- SRAMRDATA  in  32  SRAM read data, valid the cycle after a read CS
- SRAMADDR  out  AW-2  SRAM word address
- SRAMWDATA  out  32  SRAM write data
- SRAMWEN  out  4  byte write enables
- SRAMCS  out  1  SRAM chip select

Behaviour:
- Accept: acc = HSEL & HREADY & HTRANS[1]. rd_req = acc & ~HWRITE; wr_req = acc & HWRITE.
- Lane mask from HSIZE[1:0] and HADDR[1:0]:
  - byte: 1 << HADDR[1:0]
  - half: 4'b0011 if HADDR[1] = 0, else 4'b1100
  - word, and any HSIZE >= 2: 4'b1111
- Data-phase registers, loaded on every cycle with HREADY = 1: dp_rd <= rd_req, dp_wr <= wr_req, dp_addr <= HADDR[AW-1:2], dp_mask <= lane mask. When HREADY = 0 these hold.
- Write buffer state: buf_pend, buf_addr, buf_mask, buf_data.
- SRAM port priority, one access per cycle, all combinational:
  1. rd_req: SRAMCS=1, SRAMWEN=0, SRAMADDR=HADDR[AW-1:2].
  2. Else dp_wr (direct write): SRAMCS=1, SRAMWEN=dp_mask, SRAMADDR=dp_addr, SRAMWDATA=HWDATA.
  3. Else buf_pend (drain): SRAMCS=1, SRAMWEN=buf_mask, SRAMADDR=buf_addr, SRAMWDATA=buf_data; buf_pend <= 0.
  4. Else SRAMCS=0, SRAMWEN=0, SRAMADDR/SRAMWDATA=0.
- Buffer load: when dp_wr & rd_req, the write cannot use the port.
  - At the clock edge: buf_addr <= dp_addr, buf_mask <= dp_mask, buf_data <= HWDATA, buf_pend <= 1.
- Invariant: buf_pend is never 1 when a buffer load occurs. Every write data phase is preceded by a write address phase, and the first write address phase in any chain is a port-free cycle that drains the buffer. Verification asserts ~(buf_pend & dp_wr & rd_req).
- Reads:
  - HRDATA is combinational in the data phase (dp_rd = 1).
  - Per lane i: buf_data lane i if buf_pend & buf_addr == dp_addr & buf_mask[i], else SRAMRDATA lane i.
  - When dp_rd = 0, HRDATA = 0.
  - Read latency is 0 wait states: data is valid in the cycle after the address phase.
- Buffer loaded in the same cycle as a read address phase to the same word: that read's data phase forwards the new bytes.
- HREADYOUT=1 and HRESP=0 at all times, including reset.
- Reset (async, HRESETn low):
  - buf_pend, dp_rd, dp_wr, and all address/mask/data registers clear to 0.
  - SRAMCS=0, SRAMWEN=0, HRDATA=0.
  - A buffered write not yet drained is discarded; SRAM contents are untouched.
- IDLE/BUSY transfers and HSEL=0 generate no SRAM access. A pending buffer drains in such cycles.

Test Plan:
- Word write 0x0000_0010 data 0xDEADBEEF, then idle → SRAMCS=1, SRAMWEN=4'hF, SRAMADDR=0x4, SRAMWDATA=0xDEADBEEF in the data-phase cycle; read back 0x10 → HRDATA=0xDEADBEEF one cycle after its address phase.
- Byte write 0x13 data 0xAB000000, then immediately a word read of 0x10 (SRAM holds 0x11223344) → write buffered (no SRAMWEN that cycle); read HRDATA=0xAB223344 (lane 3 forwarded); next idle cycle drains with SRAMWEN=4'h8.
- Half writes 0x20/0x22 (0x1111 then 0x2222_0000) back-to-back, then read 0x20 → two direct writes with SRAMWEN=0x3 then 0xC; HRDATA=0x22221111; buf_pend never set.
- Write 0x40, then four consecutive reads of 0x80–0x8C, then idle → buffer pending through the reads, non-matching reads return SRAM data, drain occurs in the idle cycle.
- Load buffer (write + read collision), assert HRESETn low mid-stream → SRAMCS=0, HRDATA=0 immediately; after release no drain occurs and the SRAM word is unchanged.
- HREADY=0 held 3 cycles during a read data phase → dp registers hold; HREADYOUT stays 1, HRESP stays 0 throughout.

Source files
------------

// File: rtl/cmsdk_ahb_sram_bridge.sv
// AHB-Lite slave driving a synchronous single-port SRAM with zero wait states.
// A one-entry write buffer absorbs a write data phase that collides with a read address phase.
module cmsdk_ahb_sram_bridge #(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWEN,
    output logic          SRAMCS
);

    localparam int WAW = AW - 2;

    logic            acc;
    logic            rd_req;
    logic            wr_req;
    logic [3:0]      lane_mask;
    logic            trans_seq_unused;

    logic            dp_rd_reg;
    logic            dp_wr_reg;
    logic [WAW-1:0]  dp_addr_reg;
    logic [3:0]      dp_mask_reg;

    logic            buf_pend_reg;
    logic [WAW-1:0]  buf_addr_reg;
    logic [3:0]      buf_mask_reg;
    logic [31:0]     buf_data_reg;

    logic            buf_load;
    logic            buf_drain;
    logic            buf_hit;

    assign HREADYOUT        = 1'b1;
    assign HRESP            = 1'b0;
    assign trans_seq_unused = HTRANS[0];

    // Gating with HRESETn keeps the SRAM port quiet while reset is held.
    assign acc    = HSEL & HREADY & HTRANS[1] & HRESETn;
    assign rd_req = acc & ~HWRITE;
    assign wr_req = acc & HWRITE;

    always_comb begin
        lane_mask = 4'b1111;
        if (HSIZE < 3'd2) begin
            if (HSIZE[0])
                lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            else
                lane_mask = 4'b0001 << HADDR[1:0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_rd_reg   <= 1'b0;
            dp_wr_reg   <= 1'b0;
            dp_addr_reg <= '0;
            dp_mask_reg <= '0;
        end else if (HREADY) begin
            dp_rd_reg   <= rd_req;
            dp_wr_reg   <= wr_req;
            dp_addr_reg <= HADDR[AW-1:2];
            dp_mask_reg <= lane_mask;
        end
    end

    // A read address phase owns the port; a concurrent write data phase is parked.
    assign buf_load  = dp_wr_reg & rd_req;
    assign buf_drain = buf_pend_reg & ~rd_req & ~dp_wr_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_pend_reg <= 1'b0;
            buf_addr_reg <= '0;
            buf_mask_reg <= '0;
            buf_data_reg <= '0;
        end else if (buf_load) begin
            buf_pend_reg <= 1'b1;
            buf_addr_reg <= dp_addr_reg;
            buf_mask_reg <= dp_mask_reg;
            buf_data_reg <= HWDATA;
        end else if (buf_drain) begin
            buf_pend_reg <= 1'b0;
        end
    end

    always_comb begin
        SRAMCS    = 1'b0;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = '0;
        SRAMWDATA = '0;
        if (rd_req) begin
            SRAMCS   = 1'b1;
            SRAMADDR = HADDR[AW-1:2];
        end else if (dp_wr_reg) begin
            SRAMCS    = 1'b1;
            SRAMWEN   = dp_mask_reg;
            SRAMADDR  = dp_addr_reg;
            SRAMWDATA = HWDATA;
        end else if (buf_pend_reg) begin
            SRAMCS    = 1'b1;
            SRAMWEN   = buf_mask_reg;
            SRAMADDR  = buf_addr_reg;
            SRAMWDATA = buf_data_reg;
        end
    end

    // Bytes still parked in the buffer are newer than what the SRAM returned.
    assign buf_hit = buf_pend_reg & (buf_addr_reg == dp_addr_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            logic [7:0] lane_data;
            assign lane_data = (buf_hit & buf_mask_reg[gi]) ? buf_data_reg[8*gi +: 8]
                                                             : SRAMRDATA[8*gi +: 8];
            assign HRDATA[8*gi +: 8] = dp_rd_reg ? lane_data : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_cmsdk_ahb_sram_bridge.sv
// Directed bench for cmsdk_ahb_sram_bridge with a behavioural one-cycle-latency SRAM.
module tb_cmsdk_ahb_sram_bridge;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [15:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] SRAMRDATA;
    logic [13:0] SRAMADDR;
    logic [31:0] SRAMWDATA;
    logic [3:0]  SRAMWEN;
    logic        SRAMCS;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];

    cmsdk_ahb_sram_bridge #(.AW(16)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAMRDATA (SRAMRDATA),
        .SRAMADDR  (SRAMADDR),
        .SRAMWDATA (SRAMWDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMCS    (SRAMCS)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // SRAM model: registered read, byte-enabled write, output holds when not selected.
    always @(posedge HCLK) begin
        if (SRAMCS) begin
            for (int i = 0; i < 4; i++)
                if (SRAMWEN[i]) mem[SRAMADDR[7:0]][8*i +: 8] <= SRAMWDATA[8*i +: 8];
            SRAMRDATA <= mem[SRAMADDR[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic port(input string tag, input logic cs, input logic [3:0] wen,
                        input logic [13:0] addr, input logic [31:0] wdata);
        chk({tag, ".cs"}, 32'(SRAMCS), 32'(cs));
        chk({tag, ".wen"}, 32'(SRAMWEN), 32'(wen));
        if (cs) chk({tag, ".addr"}, 32'(SRAMADDR), 32'(addr));
        if (|wen) chk({tag, ".wdata"}, SRAMWDATA, wdata);
    endtask

    task automatic bus(input logic wr, input logic [2:0] size, input logic [15:0] addr,
                       input logic [31:0] wdata);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HADDR = addr; HWDATA = wdata;
        #4;
    endtask

    task automatic idle(input logic [31:0] wdata);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0; HWDATA = wdata;
        #4;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETn = 1'b0; HREADY = 1'b1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0; HWDATA = '0;
        #3;
        chk("rst.hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst.hresp", 32'(HRESP), 32'd0);
        chk("rst.hrdata", HRDATA, 32'h0);
        port("rst", 1'b0, 4'h0, 14'h0, 32'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Word write then read back.
        bus(1'b1, 3'd2, 16'h0010, 32'h0);          port("w10.ap", 1'b0, 4'h0, 14'h0, 32'h0); tick();
        idle(32'hDEADBEEF);                         port("w10.dp", 1'b1, 4'hF, 14'h4, 32'hDEADBEEF); tick();
        bus(1'b0, 3'd2, 16'h0010, 32'h0);          port("r10.ap", 1'b1, 4'h0, 14'h4, 32'h0); tick();
        idle(32'h0);                                chk("r10.data", HRDATA, 32'hDEADBEEF); tick();

        // Byte write colliding with a read of the same word.
        bus(1'b1, 3'd2, 16'h0010, 32'h0);          tick();
        idle(32'h11223344);                         tick();
        bus(1'b1, 3'd0, 16'h0013, 32'h0);          tick();
        bus(1'b0, 3'd2, 16'h0010, 32'hAB000000);   port("coll.ap", 1'b1, 4'h0, 14'h4, 32'h0); tick();
        idle(32'h0);                                chk("coll.fwd", HRDATA, 32'hAB223344);
                                                    port("coll.drain", 1'b1, 4'h8, 14'h4, 32'hAB000000); tick();
        idle(32'h0);                                port("coll.quiet", 1'b0, 4'h0, 14'h0, 32'h0);
                                                    chk("coll.idle_rd", HRDATA, 32'h0); tick();
        bus(1'b0, 3'd2, 16'h0010, 32'h0);          tick();
        idle(32'h0);                                chk("coll.mem", HRDATA, 32'hAB223344); tick();

        // Back-to-back half writes, then read.
        bus(1'b1, 3'd1, 16'h0020, 32'h0);          tick();
        bus(1'b1, 3'd1, 16'h0022, 32'h00001111);   port("h20", 1'b1, 4'h3, 14'h8, 32'h00001111); tick();
        idle(32'h22220000);                         port("h22", 1'b1, 4'hC, 14'h8, 32'h22220000); tick();
        bus(1'b0, 3'd2, 16'h0020, 32'h0);          port("h.rd_ap", 1'b1, 4'h0, 14'h8, 32'h0); tick();
        idle(32'h0);                                chk("h.data", HRDATA, 32'h22221111);
                                                    port("h.nobuf", 1'b0, 4'h0, 14'h0, 32'h0); tick();

        // Buffer stays pending across a run of reads to other words.
        bus(1'b1, 3'd2, 16'h0080, 32'h0);          tick();
        bus(1'b1, 3'd2, 16'h0084, 32'hC0DE0080);   tick();
        bus(1'b1, 3'd2, 16'h0088, 32'hC0DE0084);   tick();
        bus(1'b1, 3'd2, 16'h008C, 32'hC0DE0088);   tick();
        idle(32'hC0DE008C);                         tick();
        bus(1'b1, 3'd2, 16'h0040, 32'h0);          tick();
        bus(1'b0, 3'd2, 16'h0080, 32'h40404040);   port("run.r80", 1'b1, 4'h0, 14'h20, 32'h0); tick();
        bus(1'b0, 3'd2, 16'h0084, 32'h0);          port("run.r84", 1'b1, 4'h0, 14'h21, 32'h0);
                                                    chk("run.d80", HRDATA, 32'hC0DE0080); tick();
        bus(1'b0, 3'd2, 16'h0088, 32'h0);          chk("run.d84", HRDATA, 32'hC0DE0084); tick();
        bus(1'b0, 3'd2, 16'h008C, 32'h0);          chk("run.d88", HRDATA, 32'hC0DE0088); tick();
        idle(32'h0);                                chk("run.d8c", HRDATA, 32'hC0DE008C);
                                                    port("run.drain", 1'b1, 4'hF, 14'h10, 32'h40404040); tick();
        bus(1'b0, 3'd2, 16'h0040, 32'h0);          tick();
        idle(32'h0);                                chk("run.mem40", HRDATA, 32'h40404040); tick();

        // Reset while a buffered write is pending discards it.
        bus(1'b1, 3'd2, 16'h0050, 32'h0);          tick();
        idle(32'h55555555);                         tick();
        bus(1'b1, 3'd2, 16'h0050, 32'h0);          tick();
        bus(1'b0, 3'd2, 16'h0050, 32'h99999999);   tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
        HRESETn = 1'b0;
        #4;
        port("rst2", 1'b0, 4'h0, 14'h0, 32'h0);
        chk("rst2.hrdata", HRDATA, 32'h0);
        tick();
        HRESETn = 1'b1;
        idle(32'h0);                                port("rst2.nodrain", 1'b0, 4'h0, 14'h0, 32'h0); tick();
        bus(1'b0, 3'd2, 16'h0050, 32'h0);          tick();
        idle(32'h0);                                chk("rst2.mem50", HRDATA, 32'h55555555); tick();

        // Stalled read data phase.
        bus(1'b0, 3'd2, 16'h0040, 32'h0);          tick();
        for (int k = 0; k < 3; k++) begin
            HREADY = 1'b0;
            bus(1'b0, 3'd2, 16'h0050, 32'h0);
            chk("stall.hrdata", HRDATA, 32'h40404040);
            chk("stall.cs", 32'(SRAMCS), 32'd0);
            chk("stall.hready", 32'(HREADYOUT), 32'd1);
            chk("stall.hresp", 32'(HRESP), 32'd0);
            tick();
        end
        HREADY = 1'b1;
        bus(1'b0, 3'd2, 16'h0050, 32'h0);          chk("stall.last", HRDATA, 32'h40404040);
                                                    port("stall.ap", 1'b1, 4'h0, 14'h14, 32'h0); tick();
        idle(32'h0);                                chk("stall.next", HRDATA, 32'h55555555); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
